// File: rtl/fighter_fsm.sv
// fighter_fsm: per-player fighter controller in the game-clock domain.
// Covers horizontal movement with opponent clamping, a neutral/directional
// attack sequencer (startup/active/recovery) and self-timed hit/block stun.
// Optional feature macro: FIGHTER_ATTACK_BUFFER_EN. When it is defined, an
// attack pressed late in recovery is buffered and starts straight after
// recovery ends. When it is undefined, triggers outside IDLE are dropped.
// state_dbg_out exposes the registered FSM state for observation.
module fighter_fsm #(
    parameter int FACING_RIGHT = 1,
    parameter int X_W          = 10,
    parameter int TMR_W        = 8,
    parameter int SCREEN_W     = 640,
    parameter int CHAR_W       = 32,
    parameter int CHAR_H       = 60,
    parameter int Y_POS        = 380,
    parameter int INIT_X       = 304,
    parameter int FWD_SPD      = 3,
    parameter int BAK_SPD      = 2,
    parameter int N_STARTUP    = 5,
    parameter int N_ACTIVE     = 2,
    parameter int N_RECOV      = 16,
    parameter int D_STARTUP    = 4,
    parameter int D_ACTIVE     = 3,
    parameter int D_RECOV      = 15,
    parameter int BUF_WIN      = 4
) (
    input  logic             clk_game,
    input  logic             reset_n,
    input  logic             move_left_in,
    input  logic             move_right_in,
    input  logic             attack_in,
    input  logic             hit_in,
    input  logic             block_in,
    input  logic [TMR_W-1:0] stun_len_in,
    input  logic [X_W-1:0]   opp_x_in,
    input  logic [X_W-1:0]   opp_w_in,
    output logic [X_W-1:0]   x_pos_out,
    output logic [X_W-1:0]   y_pos_out,
    output logic [X_W-1:0]   width_out,
    output logic [X_W-1:0]   height_out,
    output logic [7:0]       color_out_332,
    output logic [1:0]       attack_phase_out,
    output logic             attack_active,
    output logic             attack_dir_out,
    output logic             moving_backward,
    output logic             stun_out,
    output logic [2:0]       state_dbg_out
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_STARTUP   = 3'd1,
        S_ACTIVE    = 3'd2,
        S_RECOVERY  = 3'd3,
        S_HITSTUN   = 3'd4,
        S_BLOCKSTUN = 3'd5
    } state_e;

    // Position arithmetic runs one bit wider than the bus so nothing wraps.
    localparam int XE = X_W + 1;
    localparam logic [XE-1:0] FWD_E    = XE'(FWD_SPD);
    localparam logic [XE-1:0] BAK_E    = XE'(BAK_SPD);
    localparam logic [XE-1:0] CHAR_W_E = XE'(CHAR_W);
    localparam logic [XE-1:0] SCR_LIM  = XE'(SCREEN_W - CHAR_W);

    localparam logic [TMR_W-1:0] N_S_M1 = TMR_W'(N_STARTUP - 1);
    localparam logic [TMR_W-1:0] N_A_M1 = TMR_W'(N_ACTIVE - 1);
    localparam logic [TMR_W-1:0] N_R_M1 = TMR_W'(N_RECOV - 1);
    localparam logic [TMR_W-1:0] D_S_M1 = TMR_W'(D_STARTUP - 1);
    localparam logic [TMR_W-1:0] D_A_M1 = TMR_W'(D_ACTIVE - 1);
    localparam logic [TMR_W-1:0] D_R_M1 = TMR_W'(D_RECOV - 1);

    state_e           state_q, state_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic [X_W-1:0]   x_q, x_d;
    logic [7:0]       color_q, color_d;
    logic             dir_q, dir_d;
    logic             prev_q;

`ifdef FIGHTER_ATTACK_BUFFER_EN
    localparam logic [TMR_W-1:0] BUF_LIM = TMR_W'(BUF_WIN);
    logic buf_q, buf_d;
    logic buf_dir_q, buf_dir_d;
`endif

    logic             fwd, bak, fwd_only, bak_only, dir_now, trig;
    logic [TMR_W-1:0] stun_m1;
    logic [X_W-1:0]   move_x;

    assign fwd      = (FACING_RIGHT != 0) ? move_right_in : move_left_in;
    assign bak      = (FACING_RIGHT != 0) ? move_left_in : move_right_in;
    assign fwd_only = fwd & ~bak;
    assign bak_only = bak & ~fwd;
    assign dir_now  = fwd_only | bak_only;
    assign trig     = attack_in & ~prev_q;
    assign stun_m1  = (stun_len_in == '0) ? '0 : stun_len_in - 1'b1;

    function automatic logic [7:0] state_color(input state_e s);
        case (s)
            S_IDLE:      return 8'hFE;
            S_STARTUP:   return 8'h1F;
            S_ACTIVE:    return 8'hE0;
            S_RECOVERY:  return 8'h38;
            S_HITSTUN:   return 8'hE4;
            S_BLOCKSTUN: return 8'hD8;
            default:     return 8'hFE;
        endcase
    endfunction

    // One movement step for the held direction, clamped against the opponent or screen edge.
    always_comb begin
        logic [XE-1:0] x_e, lim, res;
        x_e = {1'b0, x_q};
        lim = '0;
        res = x_e;
        if (FACING_RIGHT != 0) begin
            if (fwd_only) begin
                // Opponent left edge minus our width; if that is negative we cannot advance.
                if ({1'b0, opp_x_in} >= CHAR_W_E) begin
                    lim = {1'b0, opp_x_in} - CHAR_W_E;
                    if (x_e < lim) begin
                        res = ((x_e + FWD_E) > lim) ? lim : x_e + FWD_E;
                    end
                end
            end else if (bak_only) begin
                res = (x_e >= BAK_E) ? x_e - BAK_E : '0;
            end
        end else begin
            if (fwd_only) begin
                lim = {1'b0, opp_x_in} + {1'b0, opp_w_in};
                if (x_e > lim) begin
                    res = (x_e > (lim + FWD_E)) ? x_e - FWD_E : lim;
                end
            end else if (bak_only) begin
                lim = SCR_LIM;
                if (x_e < lim) begin
                    res = ((x_e + BAK_E) > lim) ? lim : x_e + BAK_E;
                end
            end
        end
        move_x = res[X_W-1:0];
    end

    // Next-state, timer, position and colour decode.
    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        x_d     = x_q;
        dir_d   = dir_q;
`ifdef FIGHTER_ATTACK_BUFFER_EN
        buf_d     = buf_q;
        buf_dir_d = buf_dir_q;
`endif
        if (hit_in) begin
            state_d = S_HITSTUN;
            tmr_d   = stun_m1;
`ifdef FIGHTER_ATTACK_BUFFER_EN
            buf_d   = 1'b0;
`endif
        end else if (block_in) begin
            state_d = S_BLOCKSTUN;
            tmr_d   = stun_m1;
`ifdef FIGHTER_ATTACK_BUFFER_EN
            buf_d   = 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (trig) begin
                        state_d = S_STARTUP;
                        dir_d   = dir_now;
                        tmr_d   = dir_now ? D_S_M1 : N_S_M1;
                    end else begin
                        x_d = move_x;
                    end
                end
                S_STARTUP: begin
                    if (tmr_q == '0) begin
                        state_d = S_ACTIVE;
                        tmr_d   = dir_q ? D_A_M1 : N_A_M1;
                    end else begin
                        tmr_d = tmr_q - 1'b1;
                    end
                end
                S_ACTIVE: begin
                    if (tmr_q == '0) begin
                        state_d = S_RECOVERY;
                        tmr_d   = dir_q ? D_R_M1 : N_R_M1;
                    end else begin
                        tmr_d = tmr_q - 1'b1;
                    end
                end
                S_RECOVERY: begin
`ifdef FIGHTER_ATTACK_BUFFER_EN
                    if (trig && (tmr_q < BUF_LIM)) begin
                        buf_d     = 1'b1;
                        buf_dir_d = dir_now;
                    end
                    if (tmr_q == '0) begin
                        if (buf_d) begin
                            state_d = S_STARTUP;
                            dir_d   = buf_dir_d;
                            tmr_d   = buf_dir_d ? D_S_M1 : N_S_M1;
                            buf_d   = 1'b0;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        tmr_d = tmr_q - 1'b1;
                    end
`else
                    if (tmr_q == '0) begin
                        state_d = S_IDLE;
                    end else begin
                        tmr_d = tmr_q - 1'b1;
                    end
`endif
                end
                S_HITSTUN, S_BLOCKSTUN: begin
                    if (tmr_q == '0) begin
                        state_d = S_IDLE;
                    end else begin
                        tmr_d = tmr_q - 1'b1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    tmr_d   = '0;
                end
            endcase
        end
        color_d = state_color(state_d);
    end

    // State, timer, position, colour and attack-edge registers.
    always_ff @(posedge clk_game or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            tmr_q   <= '0;
            x_q     <= X_W'(INIT_X);
            color_q <= 8'hFE;
            dir_q   <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            x_q     <= x_d;
            color_q <= color_d;
            dir_q   <= dir_d;
            prev_q  <= attack_in;
        end
    end

`ifdef FIGHTER_ATTACK_BUFFER_EN
    // Buffered attack request and its direction.
    always_ff @(posedge clk_game or negedge reset_n) begin
        if (!reset_n) begin
            buf_q     <= 1'b0;
            buf_dir_q <= 1'b0;
        end else begin
            buf_q     <= buf_d;
            buf_dir_q <= buf_dir_d;
        end
    end
`endif

    // Output decode from registered state.
    always_comb begin
        attack_phase_out = 2'b00;
        case (state_q)
            S_STARTUP:  attack_phase_out = 2'b01;
            S_ACTIVE:   attack_phase_out = 2'b10;
            S_RECOVERY: attack_phase_out = 2'b11;
            default:    attack_phase_out = 2'b00;
        endcase
    end

    assign attack_active   = (state_q == S_ACTIVE);
    assign stun_out        = (state_q == S_HITSTUN) || (state_q == S_BLOCKSTUN);
    assign attack_dir_out  = dir_q;
    assign moving_backward = bak_only;
    assign x_pos_out       = x_q;
    assign y_pos_out       = X_W'(Y_POS);
    assign width_out       = X_W'(CHAR_W);
    assign height_out      = X_W'(CHAR_H);
    assign color_out_332   = color_q;
    assign state_dbg_out   = state_q;

endmodule

// File: doc/fighter_fsm.md
# fighter_fsm

Parametrised per-player fighter controller for the game-clock domain. It covers horizontal movement with opponent-collision clamping, a neutral/directional attack sequencer, and self-timed hit/block stun. It generalises the single-player controller: facing side, geometry, speeds, attack frame data and stun durations are all parameters or inputs, so the same block is instantiated once per player. Outputs feed the renderer (position, size, colour) and the hit/block arbiter (attack phase, active window, backward-hold).

## Interface
- FACING_RIGHT, 1: 1 = forward is +x (left-side player); 0 = forward is −x
- X_W, 10: position/width bus width
- TMR_W, 8: frame timer and stun-length width
- SCREEN_W, 640: playfield width in px
- CHAR_W / CHAR_H, 32 / 60: sprite size
- Y_POS, 380: fixed sprite y
- INIT_X, 304: reset x position
- FWD_SPD / BAK_SPD, 3 / 2: px per frame
- N_STARTUP / N_ACTIVE / N_RECOV, 5 / 2 / 16: neutral attack phase lengths, in frames (each ≥1)
- D_STARTUP / D_ACTIVE / D_RECOV, 4 / 3 / 15: directional attack phase lengths, in frames (each ≥1)
- BUF_WIN, 4: attack buffer window in frames (see Configuration)

Ports:
- clk_game, in, 1: game-frame clock
- reset_n, in, 1: asynchronous active-low reset
- move_left_in / move_right_in, in, 1: held direction levels
- attack_in, in, 1: attack button level
- hit_in, in, 1: one-cycle pulse, opponent's attack connected unblocked
- block_in, in, 1: one-cycle pulse, opponent's attack connected and was blocked
- stun_len_in, in, TMR_W: stun length, sampled with hit_in/block_in
- opp_x_in / opp_w_in, in, X_W: opponent left edge and width
- x_pos_out, out, X_W: registered x position
- y_pos_out / width_out / height_out, out, X_W: constants Y_POS / CHAR_W / CHAR_H
- color_out_332, out, 8: registered RGB332 colour
- attack_phase_out, out, 2: 00 idle/stun, 01 startup, 10 active, 11 recovery
- attack_active, out, 1: high in ACTIVE
- attack_dir_out, out, 1: current or last attack was directional
- moving_backward, out, 1: backward input held (combinational)
- stun_out, out, 1: high in HITSTUN or BLOCKSTUN

## Operation
- States: IDLE, STARTUP, ACTIVE, RECOVERY, HITSTUN, BLOCKSTUN. Down-counter `tmr` is TMR_W wide.
- Direction decode: fwd = FACING_RIGHT ? right : left; bak = the other input. Both held or neither held → no motion and not directional.
- Attack trigger is a rising edge of attack_in against a registered previous level.
- IDLE, trigger: enter STARTUP. dir = fwd|bak as sampled that cycle. tmr = X_STARTUP−1, where X is D if dir else N. No movement that cycle.
- IDLE, no trigger: move by one step.
  - FACING_RIGHT forward: x+FWD_SPD, clamped to opp_x_in−CHAR_W; no motion if already at or past it.
  - FACING_RIGHT backward: x−BAK_SPD, saturating at 0.
  - FACING_LEFT forward: x−FWD_SPD, clamped to opp_x_in+opp_w_in.
  - FACING_LEFT backward: x+BAK_SPD, clamped to SCREEN_W−CHAR_W.
- STARTUP → ACTIVE → RECOVERY → IDLE. Each transition occurs on the cycle tmr==0 and reloads tmr with the next phase length −1. Otherwise tmr decrements. There is no movement outside IDLE.
- hit_in in any state: enter HITSTUN with tmr = max(stun_len_in,1)−1. The current attack is aborted.
- block_in (without hit_in): same behaviour, entering BLOCKSTUN.
- hit_in has priority over block_in when both arrive together.
- A new hit/block pulse during stun reloads tmr and may switch between the two stun states.
- Stun exits to IDLE on tmr==0.
- Colours: IDLE FE, STARTUP 1F, ACTIVE E0, RECOVERY 38, HITSTUN E4, BLOCKSTUN D8. The colour always matches the registered state.

## Timing
- Reset values: x=INIT_X, state IDLE, tmr 0, colour FE, phase 00, attack_active 0, attack_dir_out 0, stun_out 0, prev-attack 0.
- Trigger at cycle t → phase 01 at t+1.
- A neutral attack shows 01 for 5 cycles, 10 for 2 cycles, 11 for 16 cycles, then 00.
- Stun with len L lasts exactly L cycles (L=0 behaves as L=1).
- Position updates take effect one cycle after the input is sampled.
- All arithmetic is done at X_W+1 bits before clamping, so no wrap-around can occur.

## Configuration
- FIGHTER_ATTACK_BUFFER_EN defined:
  - A trigger during RECOVERY while tmr<BUF_WIN sets a one-bit buffer and latches its dir.
  - On the RECOVERY→IDLE cycle, a set buffer enters STARTUP directly, skipping IDLE.
  - Stun entry or reset clears the buffer.
- FIGHTER_ATTACK_BUFFER_EN undefined: triggers outside IDLE are discarded; no buffer logic is built.

## Test plan
- Reset, then FACING_RIGHT, right held 10 cycles, opp_x=400 → x = 304 + 30 = 334; hold longer → x saturates at 368.
- Single attack_in edge, no direction → phases 01×5, 10×2, 11×16, then 00; attack_active high for exactly 2 cycles.
- Right held plus attack edge → attack_dir_out=1, phases 4/3/15.
- ACTIVE phase, hit_in with stun_len=12 → HITSTUN next cycle, colour E4, 12 cycles, then IDLE; simultaneous block_in is ignored.
- BLOCKSTUN with len 10, block_in again with len 3 at cycle 5 → total stun 8 cycles.
- Buffer enabled: attack edge at tmr=2 of recovery → STARTUP the cycle after recovery ends. Buffer disabled → stays IDLE.
